wav_mcu_irq_fast: RTL and testbench
===================================

WAV_MCU_IRQ_FAST -- requirements
Module: wav_mcu_irq_fast

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 15: number of fast interrupt lines.
REQ-002 SHALL have port i_hclk  input  1  sole clock; all flops rising-edge.
REQ-003 SHALL have port i_hreset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_irq_fast  input  NUM_IRQ  raw interrupt sources, possibly asynchronous to i_hclk.
REQ-005 SHALL have port i_mcu_irq_fast_sync_cfg  input  NUM_IRQ  per bit: 1 = route through 2-flop synchronizer; 0 = bypass.
REQ-006 SHALL have port i_mcu_irq_fast_edge_cfg  input  NUM_IRQ  per bit: 1 = rising-edge detect; 0 = level.
REQ-007 SHALL have port i_mcu_irq_fast_sticky_cfg  input  NUM_IRQ  per bit: 1 = latch event until cleared; 0 = follow event.
REQ-008 SHALL have port i_mcu_irq_fast_clr_cfg  input  NUM_IRQ  per bit level clear of the sticky status.
REQ-009 SHALL have port i_mcu_irq_fast_msk_cfg  input  NUM_IRQ  per bit: 1 = block forwarding to core.
REQ-010 SHALL have port o_mcu_irq_fast_sta  output  NUM_IRQ  per-line status, pre-mask, returned to the CSR block.
REQ-011 SHALL have port o_irq_fast  output  NUM_IRQ  masked interrupts to core.
REQ-012 SHALL have port o_irq_any  output  1  OR of o_irq_fast.

Function
REQ-013 Per bit, conditioned signal c SHALL be: sync_cfg=1 -> output of 2-flop synchronizer on i_irq_fast; sync_cfg=0 -> i_irq_fast directly.
REQ-014 Synchronizer flops SHALL clock every cycle regardless of sync_cfg, so toggling sync_cfg needs no flush.
REQ-015 A previous-value flop p SHALL capture c every cycle.
REQ-016 Event e SHALL be: edge_cfg=1 -> c AND NOT p; edge_cfg=0 -> c.
REQ-017 Status flop s, sticky_cfg=1: clr_cfg=1 -> s<=0; else s <= s OR e.
REQ-018 Clear SHALL dominate a simultaneous event; an event coincident with clr_cfg=1 is lost.
REQ-019 Status flop s, sticky_cfg=0: s <= e each cycle; clr_cfg ignored.
REQ-020 Switching sticky_cfg 1->0 SHALL drop held status on the next cycle to e.
REQ-021 o_mcu_irq_fast_sta SHALL equal s (registered, unmasked).
REQ-022 o_irq_fast SHALL equal s AND NOT msk_cfg, combinational from msk_cfg; unmasking a held sticky bit asserts o_irq_fast in the same cycle.
REQ-023 o_irq_any SHALL equal OR-reduction of o_irq_fast, combinational.
REQ-024 Latency i_irq_fast rise -> o_mcu_irq_fast_sta rise SHALL be 1 cycle with sync_cfg=0 and 3 cycles with sync_cfg=1, both edge and level modes.
REQ-025 Edge mode SHALL produce exactly one event per 0->1 transition of c; a level held high SHALL produce no further events.
REQ-026 Edge mode non-sticky SHALL yield a 1-cycle status pulse per rising edge.
REQ-027 Bits SHALL be fully independent; no cross-bit priority or encoding.
REQ-028 Config changes SHALL take effect on the next clock edge with no internal state besides sync, p and s flops.

Reset
REQ-029 On i_hreset=1 at a clock edge, synchronizer flops, p and s SHALL all clear to 0.
REQ-030 During and on the cycle after reset, o_mcu_irq_fast_sta, o_irq_fast and o_irq_any SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard held sticky status and in-flight synchronizer contents.
REQ-032 Because p resets to 0, an input already high when reset deasserts SHALL generate one edge event in edge mode.

Verification
REQ-033 Level, no sync, non-sticky, unmasked bit 3: i_irq_fast=0x0008 cycle N -> sta=0x0008 and o_irq_any=1 at N+1; input low at M -> sta=0 at M+1.
REQ-034 Edge, sync, sticky bit 0: 1-cycle... held-high pulse on i_irq_fast[0] from N -> sta[0]=1 at N+3, remains 1 after input drops; clr_cfg[0]=1 one cycle -> sta[0]=0 next cycle.
REQ-035 Clear vs event: sticky level bit 5, clr_cfg[5]=1 and i_irq_fast[5]=1 same cycle -> sta[5]=0; clr dropped, input still high -> sta[5]=1 next cycle.
REQ-036 Mask: sticky bit 7 set, msk_cfg=0x0080 -> sta=0x0080, o_irq_fast=0, o_irq_any=0; msk_cfg=0 -> o_irq_fast=0x0080 same cycle.
REQ-037 Edge non-sticky, input held high 10 cycles -> exactly one 1-cycle sta pulse.
REQ-038 Reset mid-operation: sticky bits 0x7FFF held, i_hreset=1 one cycle -> all outputs 0 next cycle; inputs high in edge mode -> one event each after release.

Source files
------------

// File: rtl/wav_mcu_irq_fast.sv
// Fast interrupt conditioning: optional 2-flop synchronizer, edge/level detect,
// sticky or transparent status, and masking toward the core.
module wav_mcu_irq_fast #(
  parameter int NUM_IRQ = 15
) (
  input  logic               i_hclk,
  input  logic               i_hreset,
  input  logic [NUM_IRQ-1:0] i_irq_fast,
  input  logic [NUM_IRQ-1:0] i_mcu_irq_fast_sync_cfg,
  input  logic [NUM_IRQ-1:0] i_mcu_irq_fast_edge_cfg,
  input  logic [NUM_IRQ-1:0] i_mcu_irq_fast_sticky_cfg,
  input  logic [NUM_IRQ-1:0] i_mcu_irq_fast_clr_cfg,
  input  logic [NUM_IRQ-1:0] i_mcu_irq_fast_msk_cfg,
  output logic [NUM_IRQ-1:0] o_mcu_irq_fast_sta,
  output logic [NUM_IRQ-1:0] o_irq_fast,
  output logic               o_irq_any
);

  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] sta_q, sta_d;
  logic [NUM_IRQ-1:0] cond;
  logic [NUM_IRQ-1:0] evt;

  always_comb begin
    // Synchronizer runs unconditionally so flipping sync_cfg never sees stale data.
    sync1_d = i_irq_fast;
    sync2_d = sync1_q;
    cond    = (i_mcu_irq_fast_sync_cfg & sync2_q) | (~i_mcu_irq_fast_sync_cfg & i_irq_fast);
    prev_d  = cond;
    evt     = (i_mcu_irq_fast_edge_cfg & cond & ~prev_q) | (~i_mcu_irq_fast_edge_cfg & cond);
    // Clear beats a coincident event; non-sticky lines just follow the event.
    sta_d   = (i_mcu_irq_fast_sticky_cfg & ~i_mcu_irq_fast_clr_cfg & (sta_q | evt))
            | (~i_mcu_irq_fast_sticky_cfg & evt);
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      sta_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      sta_q   <= sta_d;
    end
  end

  // Outputs are forced quiet while reset is held, not just after it is sampled.
  assign o_mcu_irq_fast_sta = i_hreset ? '0 : sta_q;
  assign o_irq_fast         = o_mcu_irq_fast_sta & ~i_mcu_irq_fast_msk_cfg;
  assign o_irq_any          = |o_irq_fast;

endmodule

// File: tb/tb_wav_mcu_irq_fast.sv
// Scoreboard bench for wav_mcu_irq_fast: directed scenarios plus randomized traffic
// checked against a per-line behavioural model.
module tb_wav_mcu_irq_fast;
  localparam int N = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq, sync_cfg, edge_cfg, sticky_cfg, clr_cfg, msk_cfg;
  logic [N-1:0] sta, irq_out;
  logic         any;

  typedef struct packed {
    logic [N-1:0] sta;
    logic [N-1:0] irq;
    logic         any;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           passed = 0;

  // Model state: input samples from previous edges, last conditioned value, status.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_last_c, m_sta;

  wav_mcu_irq_fast #(.NUM_IRQ(N)) dut (
    .i_hclk                    (clk),
    .i_hreset                  (rst),
    .i_irq_fast                (irq),
    .i_mcu_irq_fast_sync_cfg   (sync_cfg),
    .i_mcu_irq_fast_edge_cfg   (edge_cfg),
    .i_mcu_irq_fast_sticky_cfg (sticky_cfg),
    .i_mcu_irq_fast_clr_cfg    (clr_cfg),
    .i_mcu_irq_fast_msk_cfg    (msk_cfg),
    .o_mcu_irq_fast_sta        (sta),
    .o_irq_fast                (irq_out),
    .o_irq_any                 (any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Predicts the outputs visible right after the coming rising edge.
  task automatic model_step();
    exp_t e;
    logic [N-1:0] new_last;
    if (rst) begin
      hist = '{ '0, '0 };
      m_last_c = '0;
      m_sta = '0;
      e.sta = '0;
      e.irq = '0;
      e.any = 1'b0;
    end else begin
      new_last = '0;
      for (int b = 0; b < N; b++) begin
        bit c, ev;
        c = sync_cfg[b] ? hist[1][b] : irq[b];
        ev = edge_cfg[b] ? (c && !m_last_c[b]) : c;
        if (sticky_cfg[b]) m_sta[b] = clr_cfg[b] ? 1'b0 : (m_sta[b] | ev);
        else               m_sta[b] = ev;
        new_last[b] = c;
      end
      m_last_c = new_last;
      hist.push_front(irq);
      void'(hist.pop_back());
      e.sta = m_sta;
      e.irq = m_sta & ~msk_cfg;
      e.any = |(m_sta & ~msk_cfg);
    end
    sbq.push_back(e);
  endtask

  // Inputs are set at a falling edge; tick predicts, then advances one full cycle.
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_sta", 32'(sta), 32'(e.sta));
        chk("sb_irq", 32'(irq_out), 32'(e.irq));
        chk("sb_any", 32'(any), 32'(e.any));
      end
    end
  end

  initial begin
    int pulses;
    hist = '{ '0, '0 };
    m_last_c = '0;
    m_sta = '0;
    rst = 1'b1;
    irq = '0; sync_cfg = '0; edge_cfg = '0; sticky_cfg = '0; clr_cfg = '0; msk_cfg = '0;
    @(negedge clk);
    tick();
    tick();
    chk("reset_sta", 32'(sta), 0);
    chk("reset_any", 32'(any), 0);
    rst = 1'b0;
    tick();
    chk("post_reset_sta", 32'(sta), 0);

    // Level, no sync, non-sticky bit 3
    irq = 15'h0008;
    tick();
    chk("level_sta", 32'(sta), 32'h8);
    chk("level_any", 32'(any), 1);
    irq = '0;
    tick();
    chk("level_drop", 32'(sta), 0);

    // Edge, sync, sticky bit 0
    sync_cfg = 15'h1; edge_cfg = 15'h1; sticky_cfg = 15'h1;
    irq = 15'h1;
    tick();
    tick();
    chk("sync_lat2", 32'(sta), 0);
    tick();
    chk("sync_lat3", 32'(sta), 32'h1);
    irq = '0;
    tick(); tick(); tick();
    chk("sticky_hold", 32'(sta), 32'h1);
    clr_cfg = 15'h1;
    tick();
    chk("sticky_clr", 32'(sta), 0);
    clr_cfg = '0;
    sync_cfg = '0; edge_cfg = '0;

    // Clear dominates a coincident event on sticky level bit 5
    sticky_cfg = 15'h0020;
    clr_cfg = 15'h0020; irq = 15'h0020;
    tick();
    chk("clr_dominates", 32'(sta[5]), 0);
    clr_cfg = '0;
    tick();
    chk("clr_release", 32'(sta[5]), 1);

    // Mask on sticky bit 7
    sticky_cfg = 15'h0080; irq = 15'h0080;
    tick();
    irq = '0; msk_cfg = 15'h0080;
    tick();
    chk("mask_sta", 32'(sta), 32'h80);
    chk("mask_irq", 32'(irq_out), 0);
    chk("mask_any", 32'(any), 0);
    msk_cfg = '0;
    #1;
    chk("unmask_irq", 32'(irq_out), 32'h80);
    chk("unmask_any", 32'(any), 1);
    clr_cfg = 15'h00FF;
    tick();
    clr_cfg = '0;

    // Edge non-sticky on bit 2, held high 10 cycles
    sticky_cfg = '0; edge_cfg = 15'h0004; irq = 15'h0004;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sta[2]) pulses++;
    end
    chk("edge_one_pulse", 32'(pulses), 1);
    irq = '0;
    tick();

    // Reset mid-operation with all sticky edge lines held
    sticky_cfg = 15'h7FFF; edge_cfg = 15'h7FFF; irq = 15'h7FFF;
    tick();
    chk("all_sticky", 32'(sta), 32'h7FFF);
    rst = 1'b1;
    #1;
    chk("during_reset_sta", 32'(sta), 0);
    tick();
    chk("reset_mid_sta", 32'(sta), 0);
    chk("reset_mid_irq", 32'(irq_out), 0);
    chk("reset_mid_any", 32'(any), 0);
    rst = 1'b0;
    sticky_cfg = '0;
    tick();
    chk("post_reset_edge", 32'(sta), 32'h7FFF);
    tick();
    chk("post_reset_no_repeat", 32'(sta), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      irq        = N'($urandom);
      if ($urandom_range(0, 7) == 0) sync_cfg   = N'($urandom);
      if ($urandom_range(0, 7) == 0) edge_cfg   = N'($urandom);
      if ($urandom_range(0, 7) == 0) sticky_cfg = N'($urandom);
      if ($urandom_range(0, 3) == 0) msk_cfg    = N'($urandom);
      clr_cfg = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      rst     = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
